// File: rtl/sync_updown_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The master drives the controls; the slave (counter) returns count status.
interface sync_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             enable;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             saturate;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] gray;
  logic             wrap;
  logic             at_limit;

  modport master (
    output enable, up_down, load, load_value, saturate,
    input  count, gray, wrap, at_limit
  );

  modport slave (
    input  enable, up_down, load, load_value, saturate,
    output count, gray, wrap, at_limit
  );
endinterface

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous modulo-N up/down counter with load, wrap/saturate
// mode, Gray-coded copy of the count and a registered wrap pulse for cascading.
module sync_updown_counter #(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic                 clock,
  input  logic                 clear,
  sync_updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_zero;

  // Out-of-range loads clamp to the top of the count range.
  assign w_load_clamped = (32'(bus.load_value) < MODULUS) ? bus.load_value : MAX_C;
  assign w_at_max       = (r_count == MAX_C);
  assign w_at_zero      = (r_count == ZERO_C);

  // Next-state selection: load beats enable; clear is applied in the register.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (bus.load) begin
      w_count_nxt = w_load_clamped;
    end else if (bus.enable) begin
      if (bus.up_down) begin
        if (!w_at_max) begin
          w_count_nxt = r_count + WIDTH'(1);
        end else if (!bus.saturate) begin
          w_count_nxt = ZERO_C;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count;
        end
      end else begin
        if (!w_at_zero) begin
          w_count_nxt = r_count - WIDTH'(1);
        end else if (!bus.saturate) begin
          w_count_nxt = MAX_C;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count;
        end
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= RST_C;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.count    = r_count;
  assign bus.wrap     = r_wrap;
  assign bus.gray     = to_gray(r_count);
  assign bus.at_limit = bus.up_down ? w_at_max : w_at_zero;
endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench: vector table for a MODULUS=6 counter, plus a hand-written
// full-cycle sequence for a WIDTH=4, MODULUS=16, RESET_VALUE=9 counter.
module tb_sync_updown_counter;
  logic clk = 1'b0;
  logic clr_a, clr_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sync_updown_counter_if #(.WIDTH(3)) bus_a ();
  sync_updown_counter_if #(.WIDTH(4)) bus_b ();

  sync_updown_counter #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0)) dut_a (
    .clock(clk), .clear(clr_a), .bus(bus_a)
  );
  sync_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(9)) dut_b (
    .clock(clk), .clear(clr_b), .bus(bus_b)
  );

  typedef struct {
    logic       clr, en, ud, ld;
    logic [2:0] lv;
    logic       sat;
    logic [2:0] cnt;
    logic       wr, atl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, en, ud, ld, input logic [2:0] lv,
                     input logic sat, input logic [2:0] cnt, input logic wr, atl);
    vec_t v;
    v.clr = clr; v.en = en; v.ud = ud; v.ld = ld; v.lv = lv; v.sat = sat;
    v.cnt = cnt; v.wr = wr; v.atl = atl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] eg;
    logic [3:0] exp_b, prev_g;

    clr_a = 1'b0; clr_b = 1'b0;
    bus_a.enable = 1'b0; bus_a.up_down = 1'b1; bus_a.load = 1'b0;
    bus_a.load_value = 3'd0; bus_a.saturate = 1'b0;
    bus_b.enable = 1'b0; bus_b.up_down = 1'b1; bus_b.load = 1'b0;
    bus_b.load_value = 4'd0; bus_b.saturate = 1'b0;

    //  clr   en    ud    ld    lv    sat   cnt   wrap  atl
    add(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); // 0 clear
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0); // 1 count up
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); // 6 wrap 5->0
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1); // 9 clear, down
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0); // 10 wrap 0->5
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1); // 12 saturate up
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0); // 15 load 3
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 3'd5, 1'b0, 1'b1); // 16 load clamp
    add(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0); // 17 clear beats load
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0); // 18 load 2
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0); // 19 enable toggle
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0); // 23 direction flip
    add(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); // 24 load beats enable
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); // 26 wrap
    add(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0); // 27 clear drops wrap
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); // 29 wrap
    add(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0); // 30 load clears wrap
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0); // 32 back-to-back
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0); // 33 wraps
    add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1); // 34 saturate down
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1); // 35 hold

    for (int i = 0; i < vecs.size(); i++) begin
      clr_a            = vecs[i].clr;
      bus_a.enable     = vecs[i].en;
      bus_a.up_down    = vecs[i].ud;
      bus_a.load       = vecs[i].ld;
      bus_a.load_value = vecs[i].lv;
      bus_a.saturate   = vecs[i].sat;
      tick();
      eg = vecs[i].cnt ^ (vecs[i].cnt >> 1);
      check("a_count", i, 32'(bus_a.count), 32'(vecs[i].cnt));
      check("a_wrap", i, 32'(bus_a.wrap), 32'(vecs[i].wr));
      check("a_at_limit", i, 32'(bus_a.at_limit), 32'(vecs[i].atl));
      check("a_gray", i, 32'(bus_a.gray), 32'(eg));
    end

    // Wide counter: clear to 9, count up through the wrap and a full cycle.
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    check("b_reset_count", 0, 32'(bus_b.count), 32'd9);
    check("b_reset_wrap", 0, 32'(bus_b.wrap), 32'd0);
    bus_b.enable = 1'b1;
    exp_b = 4'd9;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_b = exp_b + 4'd1;
      check("b_count_up", i, 32'(bus_b.count), 32'(exp_b));
      check("b_wrap", i, 32'(bus_b.wrap), (i == 7) ? 32'd1 : 32'd0);
    end
    check("b_at_zero", 7, 32'(bus_b.count), 32'd0);
    prev_g = bus_b.gray;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_b = exp_b + 4'd1;
      check("b_cycle_count", i, 32'(bus_b.count), 32'(exp_b));
      check("b_gray_1bit", i, 32'($countones(bus_b.gray ^ prev_g)), 32'd1);
      check("b_at_limit", i, 32'(bus_b.at_limit), (exp_b == 4'd15) ? 32'd1 : 32'd0);
      prev_g = bus_b.gray;
    end
    bus_b.enable = 1'b0;
    tick();
    check("b_hold", 0, 32'(bus_b.count), 32'(exp_b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
